alu_arbiter: RTL
================

ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 Parameter: MUL_CYCLES, 3, execute cycles occupied by a MUL (legal 1..15).
REQ-002 clk_i  in  1  single clock; all state updates on rising edge.
REQ-003 rst_i  in  1  reset, asynchronous, active-low.
REQ-004 req0_i / req1_i  in  1  requester 0/1 operation request, held until granted.
REQ-005 ctrl0_i / ctrl1_i  in  3  requester opcode: 000 AND, 001 OR, 010 ADD, 110 SUB, 111 MUL.
REQ-006 a0_i, b0_i / a1_i, b1_i  in  32  requester operands.
REQ-007 gnt0_o / gnt1_o  out  1  combinational accept; operands and opcode captured on that edge.
REQ-008 done_o  out  1  one-cycle pulse: result_o, zero_o and done_id_o valid.
REQ-009 done_id_o  out  1  index of the requester owning the completing result.
REQ-010 result_o  out  32  registered result, low 32 bits of the operation.
REQ-011 zero_o  out  1  SUB result equal to zero.
REQ-012 busy_o  out  1  high in state EXEC.

Function
REQ-013 FSM states: IDLE, EXEC; only IDLE grants.
REQ-014 IDLE, at least one req: exactly one gnt high; capture ctrl/a/b/id; load cnt = MUL_CYCLES-1 for MUL, else 0; go to EXEC.
REQ-015 IDLE, no req: both gnt low; stay in IDLE.
REQ-016 EXEC, cnt != 0: decrement cnt; stay in EXEC.
REQ-017 EXEC, cnt == 0: register result, assert done_o for the next cycle, return to IDLE.
REQ-018 Latency: done_o at grant edge + 2 cycles for non-MUL ops, grant edge + MUL_CYCLES + 1 cycles for MUL.
REQ-019 Done cycle is IDLE: a new grant in the same cycle as done_o is legal; back-to-back throughput is one non-MUL op per 2 cycles.
REQ-020 Arithmetic: ADD/SUB/MUL wrap modulo 2^32; MUL keeps the low 32 bits.
REQ-021 zero_o = 1 only for SUB with a zero result; 0 for all other ops.
REQ-022 Undefined opcode: result_o = 0, zero_o = 0, non-MUL latency.
REQ-023 result_o, zero_o and done_id_o hold their value until the next completion; only done_o pulses.
REQ-024 Requester deasserting req before grant: no grant, no side effect.
REQ-025 gnt never asserted while busy_o = 1.

Reset
REQ-026 Asynchronous reset: state IDLE, cnt 0, done_o 0, result_o 0, zero_o 0, done_id_o 0, busy_o 0, gnt outputs 0, RR pointer = "last granted 1".
REQ-027 Reset during EXEC: abandon the in-flight op; no done_o after release.
REQ-028 First grant is evaluated in the first IDLE cycle after reset release.

Configuration
REQ-029 Macro ALU_ARBITER_RR_EN defined: round-robin; on simultaneous requests, grant the requester not granted last; pointer updates on every grant.
REQ-030 Macro ALU_ARBITER_RR_EN absent: fixed priority; requester 0 always wins a tie; no pointer register.

Structure
REQ-031 Shared package alu_arb_pkg holds the opcode constants (AND/OR/ADD/SUB/MUL), the FSM state enum, and the counter width.
REQ-032 One sub-module, alu_arb_pick: 2-way pick logic (req0, req1, last-granted) -> one-hot grant; the pointer stays in the parent.
REQ-033 The compute datapath is inline in alu_arbiter; no separate ALU instance.

Verification
REQ-034 req0 ADD a=5 b=7 alone -> gnt0 at cycle 0; done_o at cycle 2, result 12, done_id 0, zero 0.
REQ-035 req1 SUB a=9 b=9 -> result 0, zero_o 1; SUB a=3 b=5 -> result 0xFFFFFFFE, zero 0.
REQ-036 req0 MUL a=0x10000 b=0x10000, MUL_CYCLES=3 -> busy for 3 cycles, done at grant+4, result 0.
REQ-037 Both requesters held continuously with RR_EN -> grants alternate 0,1,0,1; without the macro -> all grants to 0.
REQ-038 Assert rst_i low mid-MUL -> outputs immediately at reset values, no done_o after release, next request served normally.
REQ-039 Opcode 011 a=1 b=1 -> done at grant+2, result 0, zero 0.

Source files
------------

// File: rtl/alu_arb_pkg.sv
// Shared definitions for the two-requester ALU arbiter: opcode encodings,
// FSM state type and the execute-counter width.
package alu_arb_pkg;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_OR  = 3'b001;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SUB = 3'b110;
    localparam logic [2:0] OP_MUL = 3'b111;

    // Wide enough for MUL_CYCLES-1 with MUL_CYCLES up to 15
    localparam int CNT_W = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_e;

endpackage

// File: rtl/alu_arb_pick.sv
// Two-way pick: one-hot grant from two requests; on a tie the requester
// that was not granted last wins (last_i = index of the last granted one).
module alu_arb_pick (
    input  logic       req0_i,
    input  logic       req1_i,
    input  logic       last_i,
    output logic [1:0] gnt_o
);

    always_comb begin
        gnt_o = 2'b00;
        if (req0_i && req1_i) begin
            gnt_o = last_i ? 2'b01 : 2'b10;
        end else if (req0_i) begin
            gnt_o = 2'b01;
        end else if (req1_i) begin
            gnt_o = 2'b10;
        end
    end

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of a shared multi-cycle ALU.
// Define ALU_ARBITER_RR_EN for round-robin tie-breaking; otherwise requester 0 has fixed priority.
module alu_arbiter
    import alu_arb_pkg::*;
#(
    parameter int MUL_CYCLES = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req0_i,
    input  logic        req1_i,
    input  logic [2:0]  ctrl0_i,
    input  logic [2:0]  ctrl1_i,
    input  logic [31:0] a0_i,
    input  logic [31:0] b0_i,
    input  logic [31:0] a1_i,
    input  logic [31:0] b1_i,
    output logic        gnt0_o,
    output logic        gnt1_o,
    output logic        done_o,
    output logic        done_id_o,
    output logic [31:0] result_o,
    output logic        zero_o,
    output logic        busy_o,
    output state_e      state_o
);

    // Handshake: a request is accepted in the IDLE cycle where its gnt is
    // high; operands and opcode are captured on the rising edge ending it.
    localparam logic [CNT_W-1:0] MUL_LOAD = CNT_W'(MUL_CYCLES - 1);

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [2:0]        op_q, op_d;
    logic [31:0]       a_q, a_d;
    logic [31:0]       b_q, b_d;
    logic              id_q, id_d;
    logic              done_q, done_d;
    logic              done_id_q, done_id_d;
    logic [31:0]       result_q, result_d;
    logic              zero_q, zero_d;

    logic [1:0]        pick_gnt;
    logic [1:0]        gnt_w;
    logic              last_w;
    logic [31:0]       sub_w;
    logic [31:0]       alu_res;
    logic              alu_zero;

    alu_arb_pick u_pick (
        .req0_i (req0_i),
        .req1_i (req1_i),
        .last_i (last_w),
        .gnt_o  (pick_gnt)
    );

`ifdef ALU_ARBITER_RR_EN
    logic last_q, last_d;

    always_comb begin
        last_d = last_q;
        if (gnt_w != 2'b00) begin
            last_d = gnt_w[1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            last_q <= 1'b1;
        end else begin
            last_q <= last_d;
        end
    end

    assign last_w = last_q;
`else
    // Treating requester 1 as always "last granted" gives fixed priority to 0
    assign last_w = 1'b1;
`endif

    always_comb begin
        sub_w    = a_q - b_q;
        alu_res  = '0;
        case (op_q)
            OP_AND:  alu_res = a_q & b_q;
            OP_OR:   alu_res = a_q | b_q;
            OP_ADD:  alu_res = a_q + b_q;
            OP_SUB:  alu_res = sub_w;
            OP_MUL:  alu_res = a_q * b_q;
            default: alu_res = '0;
        endcase
        alu_zero = (op_q == OP_SUB) && (sub_w == '0);
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        op_d      = op_q;
        a_d       = a_q;
        b_d       = b_q;
        id_d      = id_q;
        done_d    = 1'b0;
        done_id_d = done_id_q;
        result_d  = result_q;
        zero_d    = zero_q;
        gnt_w     = 2'b00;

        case (state_q)
            ST_IDLE: begin
                if (req0_i || req1_i) begin
                    gnt_w   = pick_gnt;
                    id_d    = pick_gnt[1];
                    op_d    = pick_gnt[1] ? ctrl1_i : ctrl0_i;
                    a_d     = pick_gnt[1] ? a1_i : a0_i;
                    b_d     = pick_gnt[1] ? b1_i : b0_i;
                    cnt_d   = (op_d == OP_MUL) ? MUL_LOAD : '0;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    result_d  = alu_res;
                    zero_d    = alu_zero;
                    done_id_d = id_q;
                    done_d    = 1'b1;
                    state_d   = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            op_q      <= OP_AND;
            a_q       <= '0;
            b_q       <= '0;
            id_q      <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= 1'b0;
            result_q  <= '0;
            zero_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            op_q      <= op_d;
            a_q       <= a_d;
            b_q       <= b_d;
            id_q      <= id_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
            result_q  <= result_d;
            zero_q    <= zero_d;
        end
    end

    assign gnt0_o    = gnt_w[0];
    assign gnt1_o    = gnt_w[1];
    assign done_o    = done_q;
    assign done_id_o = done_id_q;
    assign result_o  = result_q;
    assign zero_o    = zero_q;
    assign busy_o    = (state_q == ST_EXEC);
    assign state_o   = state_q;

endmodule
